// File: rtl/zbt_bank_arbiter_pkg.sv
// Shared widths, requester tags and buffer reset locations
// for the ZBT bank arbiter.
package zbt_bank_arbiter_pkg;

    localparam int LOG_ADDR = 19;
    localparam int LOG_MEM  = 36;

    typedef logic [LOG_ADDR-1:0] addr_t;
    typedef logic [LOG_MEM-1:0]  word_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_PROC = 2'd2
    } tag_e;

    typedef enum logic {
        RR_CAM  = 1'b0,
        RR_PROC = 1'b1
    } rr_e;

    localparam logic [1:0] BUF_WRITE_RST   = 2'd0;
    localparam logic [1:0] BUF_DISPLAY_RST = 2'd1;
    localparam logic [1:0] BUF_SPARE_RST   = 2'd2;

endpackage

// File: rtl/zbt_bank_arbiter_if.sv
// Client request/grant signals plus the ZBT pin-side bus.
// slave = arbiter side, master = clients and bank side.
interface zbt_bank_arbiter_if;
    import zbt_bank_arbiter_pkg::*;

    logic  d_req;
    addr_t d_addr;
    logic  d_gnt;
    logic  d_rvalid;
    logic  c_req;
    addr_t c_addr;
    word_t c_wdata;
    logic  c_gnt;
    logic  p_req;
    logic  p_wr;
    addr_t p_addr;
    word_t p_wdata;
    logic  p_gnt;
    logic  p_rvalid;
    word_t rdata;
    addr_t mem_addr;
    word_t mem_write;
    logic  mem_we;
    word_t mem_read;

    modport slave (
        input  d_req, d_addr, c_req, c_addr, c_wdata,
        input  p_req, p_wr, p_addr, p_wdata, mem_read,
        output d_gnt, d_rvalid, c_gnt, p_gnt, p_rvalid,
        output rdata, mem_addr, mem_write, mem_we
    );

    modport master (
        output d_req, d_addr, c_req, c_addr, c_wdata,
        output p_req, p_wr, p_addr, p_wdata, mem_read,
        input  d_gnt, d_rvalid, c_gnt, p_gnt, p_rvalid,
        input  rdata, mem_addr, mem_write, mem_we
    );

endinterface

// File: rtl/zbt_bank_arbiter_buffer_rotator.sv
// Triple-buffer loc permutation: camera write, display, spare,
// plus the flag saying the spare holds a finished frame.
module zbt_bank_arbiter_buffer_rotator
    import zbt_bank_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_done,
    input  logic       vsync,
    output logic [1:0] loc_write,
    output logic [1:0] loc_display,
    output logic [1:0] loc_spare
);

    logic [1:0] wr_q, wr_d;
    logic [1:0] ds_q, ds_d;
    logic [1:0] sp_q, sp_d;
    logic       fresh_q, fresh_d;

    always_comb begin
        wr_d    = wr_q;
        ds_d    = ds_q;
        sp_d    = sp_q;
        fresh_d = fresh_q;
        if (frame_done && vsync) begin
            // display jumps straight to the frame just finished
            ds_d    = wr_q;
            wr_d    = ds_q;
            fresh_d = 1'b0;
        end else if (frame_done) begin
            wr_d    = sp_q;
            sp_d    = wr_q;
            fresh_d = 1'b1;
        end else if (vsync && fresh_q) begin
            ds_d    = sp_q;
            sp_d    = ds_q;
            fresh_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q    <= BUF_WRITE_RST;
            ds_q    <= BUF_DISPLAY_RST;
            sp_q    <= BUF_SPARE_RST;
            fresh_q <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            ds_q    <= ds_d;
            sp_q    <= sp_d;
            fresh_q <= fresh_d;
        end
    end

    assign loc_write   = wr_q;
    assign loc_display = ds_q;
    assign loc_spare   = sp_q;

endmodule

// File: rtl/zbt_bank_arbiter.sv
// One-access-per-cycle ZBT bank shared by display, camera and
// processor, with tagged read return and buffer rotation.
module zbt_bank_arbiter
    import zbt_bank_arbiter_pkg::*;
#(
    parameter int READ_LAT       = 2,
    parameter int DISP_MAX_BURST = 8
) (
    input  logic              clock,
    input  logic              reset,
    zbt_bank_arbiter_if.slave bus,
    input  logic              cam_frame_done,
    input  logic              disp_vsync,
    output logic [1:0]        buf_write,
    output logic [1:0]        buf_display,
    output logic [1:0]        buf_spare
);

    localparam int PD = READ_LAT + 1;
    localparam int BW = $clog2(DISP_MAX_BURST + 1);
    localparam logic [BW-1:0] BMAX = BW'(DISP_MAX_BURST);

    logic [BW-1:0] burst_q, burst_d;
    rr_e           rr_q, rr_d;
    addr_t         addr_q, addr_d;
    word_t         wdat_q, wdat_d;
    logic          we_q, we_d;
    tag_e          tag_q [PD];
    tag_e          tag_d [PD];
    tag_e          tag_in;
    word_t         rdata_q, rdata_d;
    logic          drv_q, drv_d;
    logic          prv_q, prv_d;
    logic          d_win, c_win, p_win;

    always_comb begin
        d_win = 1'b0;
        c_win = 1'b0;
        p_win = 1'b0;
        if (reset) begin
            // saturated display only yields to a real competitor
            if (bus.d_req && burst_q < BMAX) begin
                d_win = 1'b1;
            end else if (bus.c_req && bus.p_req) begin
                c_win = (rr_q == RR_CAM);
                p_win = (rr_q == RR_PROC);
            end else if (bus.c_req) begin
                c_win = 1'b1;
            end else if (bus.p_req) begin
                p_win = 1'b1;
            end else if (bus.d_req) begin
                d_win = 1'b1;
            end
        end
    end

    always_comb begin
        burst_d = '0;
        rr_d    = rr_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        we_d    = 1'b0;
        tag_in  = TAG_NONE;
        unique case (1'b1)
            d_win: begin
                burst_d = (burst_q == BMAX) ? burst_q : burst_q + 1'b1;
                addr_d  = bus.d_addr;
                tag_in  = TAG_DISP;
            end
            c_win: begin
                rr_d   = RR_PROC;
                addr_d = bus.c_addr;
                wdat_d = bus.c_wdata;
                we_d   = 1'b1;
            end
            p_win: begin
                rr_d   = RR_CAM;
                addr_d = bus.p_addr;
                wdat_d = bus.p_wdata;
                we_d   = bus.p_wr;
                tag_in = bus.p_wr ? TAG_NONE : TAG_PROC;
            end
            default: ;
        endcase

        tag_d[0] = tag_in;
        for (int i = 1; i < PD; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        drv_d   = (tag_q[PD-1] == TAG_DISP);
        prv_d   = (tag_q[PD-1] == TAG_PROC);
        rdata_d = (drv_d || prv_d) ? bus.mem_read : rdata_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            burst_q <= '0;
            rr_q    <= RR_CAM;
            addr_q  <= '0;
            wdat_q  <= '0;
            we_q    <= 1'b0;
            tag_q   <= '{default: TAG_NONE};
            rdata_q <= '0;
            drv_q   <= 1'b0;
            prv_q   <= 1'b0;
        end else begin
            burst_q <= burst_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            we_q    <= we_d;
            tag_q   <= tag_d;
            rdata_q <= rdata_d;
            drv_q   <= drv_d;
            prv_q   <= prv_d;
        end
    end

    assign bus.d_gnt     = d_win;
    assign bus.c_gnt     = c_win;
    assign bus.p_gnt     = p_win;
    assign bus.d_rvalid  = drv_q;
    assign bus.p_rvalid  = prv_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_write = wdat_q;
    assign bus.mem_we    = we_q;

    zbt_bank_arbiter_buffer_rotator u_rot (
        .clock       (clock),
        .reset       (reset),
        .frame_done  (cam_frame_done),
        .vsync       (disp_vsync),
        .loc_write   (buf_write),
        .loc_display (buf_display),
        .loc_spare   (buf_spare)
    );

endmodule

// File: tb/tb_zbt_bank_arbiter.sv
// Randomised bench for zbt_bank_arbiter with a cycle model,
// a bank model and directed literal checks.
module tb_zbt_bank_arbiter;
    import zbt_bank_arbiter_pkg::*;

    localparam int RL   = 2;
    localparam int MAXB = 8;
    localparam int RET  = RL + 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cam_frame_done;
    logic       disp_vsync;
    logic [1:0] buf_write, buf_display, buf_spare;

    zbt_bank_arbiter_if bus();

    zbt_bank_arbiter #(.READ_LAT(RL), .DISP_MAX_BURST(MAXB)) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .cam_frame_done (cam_frame_done),
        .disp_vsync     (disp_vsync),
        .buf_write      (buf_write),
        .buf_display    (buf_display),
        .buf_spare      (buf_spare)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic word_t pat(input addr_t a);
        if (a == 19'h00100) return 36'hABCDE0123;
        return {a[16:0], ~a};
    endfunction

    // bank: data valid RL cycles after the address is on the pins
    word_t bank   [0:524287];
    bit    bvalid [0:524287];
    addr_t a1;

    always @(posedge clock) begin
        bus.mem_read <= bvalid[a1] ? bank[a1] : pat(a1);
        a1 <= bus.mem_addr;
        if (bus.mem_we) begin
            bank[bus.mem_addr]   <= bus.mem_write;
            bvalid[bus.mem_addr] <= 1'b1;
        end
    end

    typedef struct {
        int    due;
        tag_e  tag;
        word_t data;
    } ret_t;

    ret_t  rq[$];
    word_t shadow [addr_t];
    int    cyc;
    int    m_burst;
    bit    m_rr_proc;
    addr_t m_addr;
    logic  m_we;
    word_t m_wdat;
    int    m_w, m_d, m_s;
    bit    m_fresh;

    function automatic word_t srd(input addr_t a);
        return shadow.exists(a) ? shadow[a] : pat(a);
    endfunction

    always @(negedge clock) begin
        int   g;
        bit   ed, ep;
        word_t er;
        ret_t r;
        if (!reset) begin
            rq.delete();
            m_burst = 0; m_rr_proc = 0; m_addr = '0; m_we = 0; m_wdat = '0;
            m_w = 0; m_d = 1; m_s = 2; m_fresh = 0;
            chk("rst_mem", {bus.mem_we, bus.mem_addr, bus.mem_write}, 64'd0);
            chk("rst_out", {bus.d_gnt, bus.c_gnt, bus.p_gnt,
                            bus.d_rvalid, bus.p_rvalid, bus.rdata}, 64'd0);
            chk("rst_buf", {buf_write, buf_display, buf_spare}, 6'b00_01_10);
        end else begin
            cyc++;
            chk("mem_we", bus.mem_we, m_we);
            chk("mem_addr", bus.mem_addr, m_addr);
            if (m_we) chk("mem_write", bus.mem_write, m_wdat);
            chk("bufs", {buf_write, buf_display, buf_spare},
                {m_w[1:0], m_d[1:0], m_s[1:0]});
            ed = 0; ep = 0; er = '0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                r = rq.pop_front();
                ed = (r.tag == TAG_DISP);
                ep = (r.tag == TAG_PROC);
                er = r.data;
            end
            chk("rvalid", {bus.d_rvalid, bus.p_rvalid}, {ed, ep});
            if (ed || ep) chk("rdata", bus.rdata, er);

            if (bus.d_req && m_burst < MAXB) g = 1;
            else if (bus.c_req && bus.p_req) g = m_rr_proc ? 3 : 2;
            else if (bus.c_req) g = 2;
            else if (bus.p_req) g = 3;
            else if (bus.d_req) g = 1;
            else g = 0;
            chk("gnt", {bus.d_gnt, bus.c_gnt, bus.p_gnt},
                {g == 1, g == 2, g == 3});

            m_we = 0;
            case (g)
                1: begin
                    m_burst = (m_burst < MAXB) ? m_burst + 1 : MAXB;
                    m_addr  = bus.d_addr;
                    rq.push_back('{cyc + RET, TAG_DISP, srd(bus.d_addr)});
                end
                2: begin
                    m_burst = 0; m_rr_proc = 1;
                    m_addr = bus.c_addr; m_we = 1; m_wdat = bus.c_wdata;
                    shadow[bus.c_addr] = bus.c_wdata;
                end
                3: begin
                    m_burst = 0; m_rr_proc = 0;
                    m_addr = bus.p_addr; m_we = bus.p_wr;
                    if (bus.p_wr) begin
                        m_wdat = bus.p_wdata;
                        shadow[bus.p_addr] = bus.p_wdata;
                    end else begin
                        rq.push_back('{cyc + RET, TAG_PROC, srd(bus.p_addr)});
                    end
                end
                default: m_burst = 0;
            endcase

            if (cam_frame_done && disp_vsync) begin
                int t;
                t = m_d; m_d = m_w; m_w = t; m_fresh = 0;
            end else if (cam_frame_done) begin
                int t;
                t = m_w; m_w = m_s; m_s = t; m_fresh = 1;
            end else if (disp_vsync && m_fresh) begin
                int t;
                t = m_d; m_d = m_s; m_s = t; m_fresh = 0;
            end
        end
    end

    task automatic idle_inputs();
        bus.d_req = 0; bus.d_addr = '0;
        bus.c_req = 0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.p_req = 0; bus.p_wr = 0; bus.p_addr = '0; bus.p_wdata = '0;
        cam_frame_done = 0; disp_vsync = 0;
    endtask

    function automatic addr_t raddr();
        if ($urandom_range(0, 3) == 0) return addr_t'($urandom());
        return addr_t'($urandom_range(0, 15));
    endfunction

    function automatic word_t rword();
        return word_t'({$urandom(), $urandom()});
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int gs[32];
        bit dg, cg, pg;
        int dp, cp, pp;
        idle_inputs();
        #2 reset = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1;
        repeat (20) @(negedge clock);
        chk("idle_buf", {buf_write, buf_display, buf_spare}, 6'b00_01_10);
        chk("idle_we", bus.mem_we, 1'b0);

        step();
        bus.p_req = 1; bus.p_wr = 0; bus.p_addr = 19'h00100;
        @(negedge clock);
        chk("pread_gnt", bus.p_gnt, 1'b1);
        step();
        bus.p_req = 0;
        @(negedge clock);
        chk("pread_addr", bus.mem_addr, 19'h00100);
        repeat (2) @(negedge clock);
        chk("pread_early", bus.p_rvalid, 1'b0);
        @(negedge clock);
        chk("pread_ret", {bus.p_rvalid, bus.rdata}, {1'b1, 36'hABCDE0123});

        step();
        bus.c_req = 1; bus.c_addr = 19'h10; bus.c_wdata = 36'h111111111;
        bus.p_req = 1; bus.p_wr = 1; bus.p_addr = 19'h20;
        bus.p_wdata = 36'h222222222;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            if (i > 0) begin
                chk("cp_issue", {bus.mem_we, bus.mem_addr, bus.mem_write},
                    (i % 2 == 1) ? {1'b1, 19'h10, 36'h111111111}
                                 : {1'b1, 19'h20, 36'h222222222});
            end
            if (i < 6) begin
                gs[i] = bus.c_gnt ? 1 : (bus.p_gnt ? 2 : 0);
                chk("cp_alt", gs[i], (i % 2 == 0) ? 1 : 2);
            end
            step();
            if (i == 5) idle_inputs();
        end

        bus.d_req = 1; bus.d_addr = 19'h40;
        bus.c_req = 1; bus.c_addr = 19'h11; bus.c_wdata = 36'h333333333;
        for (int i = 0; i < 27; i++) begin
            @(negedge clock);
            gs[0] = bus.c_gnt ? 2 : (bus.d_gnt ? 1 : 0);
            chk("burst_seq", gs[0], (i % 9 == 8) ? 2 : 1);
            step();
        end
        idle_inputs();
        repeat (6) step();

        cam_frame_done = 1;
        step();
        cam_frame_done = 0;
        @(negedge clock);
        chk("rot_fd", {buf_write, buf_display, buf_spare}, 6'b10_01_00);
        repeat (4) @(posedge clock);
        #1 disp_vsync = 1;
        step();
        disp_vsync = 0;
        @(negedge clock);
        chk("rot_vs", {buf_write, buf_display, buf_spare}, 6'b10_00_01);
        step();
        disp_vsync = 1;
        step();
        disp_vsync = 0;
        @(negedge clock);
        chk("rot_vs2", {buf_write, buf_display, buf_spare}, 6'b10_00_01);

        step();
        reset = 0;
        step();
        reset = 1; cam_frame_done = 1; disp_vsync = 1;
        step();
        cam_frame_done = 0; disp_vsync = 0;
        @(negedge clock);
        chk("rot_both", {buf_write, buf_display, buf_spare}, 6'b01_00_10);
        step();
        disp_vsync = 1;
        step();
        disp_vsync = 0;
        @(negedge clock);
        chk("rot_nofresh", {buf_write, buf_display, buf_spare}, 6'b01_00_10);

        dp = 60; cp = 30; pp = 30;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            dg = bus.d_gnt; cg = bus.c_gnt; pg = bus.p_gnt;
            step();
            if (n % 500 == 0) begin
                dp = $urandom_range(10, 95);
                cp = $urandom_range(10, 80);
                pp = $urandom_range(10, 80);
            end
            if (n >= 1500 && n < 1502) begin
                reset = 0;
                idle_inputs();
            end else begin
                reset = 1;
                if (!bus.d_req || dg) begin
                    bus.d_req = ($urandom_range(0, 99) < dp);
                    bus.d_addr = raddr();
                end
                if (!bus.c_req || cg) begin
                    bus.c_req = ($urandom_range(0, 99) < cp);
                    bus.c_addr = raddr();
                    bus.c_wdata = rword();
                end
                if (!bus.p_req || pg) begin
                    bus.p_req = ($urandom_range(0, 99) < pp);
                    bus.p_wr = $urandom_range(0, 1) == 1;
                    bus.p_addr = raddr();
                    bus.p_wdata = rword();
                end
                cam_frame_done = ($urandom_range(0, 29) == 0);
                disp_vsync = ($urandom_range(0, 19) == 0);
            end
        end
        idle_inputs();
        repeat (8) @(negedge clock);
        chk("drain", rq.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/zbt_bank_arbiter.md
Name: zbt_bank_arbiter

Overview:
Shares one ZBT SRAM bank (19-bit word address, 36-bit word, one access per cycle) between three requesters. The requesters are the display read path, the camera write path and the processing read/write path. The block also schedules triple-buffer rotation: it tells each client which frame-buffer location (loc 0..2) it owns, and those loc values feed the existing address calculator upstream. It sits between the clients and the ZBT pin registers, one instance per bank.

Parameters:
READ_LAT, 2, cycles from mem_addr driven to mem_read valid at the bank.
DISP_MAX_BURST, 8, max consecutive display grants before a pending non-display request must win.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
d_req  in  1  display read request
d_addr  in  19  display read address
d_gnt  out  1  display request accepted this cycle
d_rvalid  out  1  rdata holds display read data
c_req  in  1  camera write request
c_addr  in  19  camera write address
c_wdata  in  36  camera write data
c_gnt  out  1  camera request accepted this cycle
p_req  in  1  processor request
p_wr  in  1  processor: 1=write, 0=read
p_addr  in  19  processor address
p_wdata  in  36  processor write data
p_gnt  out  1  processor request accepted this cycle
p_rvalid  out  1  rdata holds processor read data
rdata  out  36  shared read-return data
mem_addr  out  19  ZBT address (registered)
mem_write  out  36  ZBT write data (registered)
mem_we  out  1  ZBT write enable (registered)
mem_read  in  36  ZBT read data
cam_frame_done  in  1  one-cycle pulse: camera finished a frame
disp_vsync  in  1  one-cycle pulse: display frame boundary
buf_write  out  2  loc owned by camera
buf_display  out  2  loc owned by display
buf_spare  out  2  loc held in reserve

Behaviour:
- Reset (reset low, async) values:
  - all gnt/rvalid = 0, mem_we = 0, mem_addr = 0, mem_write = 0, rdata = 0.
  - buf_write = 0, buf_display = 1, buf_spare = 2; fresh flag = 0; burst counter = 0; round-robin pointer = camera.
  - In-flight reads are discarded.
- Request protocol: req, addr, wr and wdata are held stable until gnt. gnt is combinational from the current requests and arbiter state, at most one gnt per cycle. The requester may change its inputs in the cycle after gnt.
- Arbitration:
  - Display wins if d_req=1 and burst counter < DISP_MAX_BURST.
  - Otherwise camera and processor share round-robin. The pointer moves to the other requester after each grant to either.
  - If the burst counter has saturated and neither camera nor processor is requesting, display is still granted.
  - Burst counter increments on each display grant and clears on any non-display grant or any idle cycle.
- Issue: in the grant cycle+1, mem_addr/mem_write/mem_we take the granted request's values. With no grant, mem_we=0 and mem_addr holds its previous value. Camera grants always write.
- Read return:
  - A shift pipeline of depth READ_LAT+1 carries a tag (none/display/processor).
  - At grant+1+READ_LAT+1 (4 cycles after gnt at default), rdata is registered from mem_read and the matching rvalid pulses for 1 cycle.
  - Back-to-back reads return in grant order at 1 per cycle. Writes insert no return.
  - Read-after-write to the same address in consecutive cycles returns the new data; no hazard logic is required (ZBT guarantees this).
- Buffer rotation: a 2-bit permutation of {0,1,2}, always distinct values.
  - cam_frame_done alone: swap buf_write and buf_spare; fresh=1.
  - disp_vsync alone with fresh=1: swap buf_display and buf_spare; fresh=0.
  - disp_vsync alone with fresh=0: no change.
  - Both in the same cycle: buf_display takes the old buf_write, buf_write takes the old buf_display, buf_spare is unchanged, fresh=0.
  - Rotation changes take effect the cycle after the pulse. In-flight accesses are unaffected.

Decomposition:
- Shared params.v supplies LOG_ADDR (19) and LOG_MEM (36). It also gets the requester-tag encoding (TAG_NONE=0, TAG_DISP=1, TAG_PROC=2) and the buffer reset locs.
- One natural sub-module, buffer_rotator, holds the three loc registers plus the fresh flag. The arbiter/pipeline stays in the top module.

Test Plan:
- Reset release, no requests → mem_we=0, buf_write/display/spare = 0/1/2, no gnt or rvalid for 20 cycles.
- Processor read 0x00100, bank returns 0xABCDE0123 → p_gnt at t0, mem_addr=0x00100 at t0+1, p_rvalid with rdata=0xABCDE0123 at t0+4.
- d_req and c_req held high for 20 cycles → display granted 8 in a row, then 1 camera grant, repeating; no request is starved.
- c_req and p_req high (write, addresses 0x10/0x20) → grants alternate c,p,c,p; mem_we=1 each cycle with the matching addr and data.
- cam_frame_done, then disp_vsync 5 cycles later → buf_write=2, spare=0, then display=0, spare=1. A second disp_vsync causes no change.
- cam_frame_done and disp_vsync in the same cycle from reset state → buf_write=1, display=0, spare=2, fresh=0.
